mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Memory stage of the 5-stage ARM pipeline. It sits directly downstream of the execute-stage register and upstream of write-back.
- Turns a load or store from the execute-stage register into a two-access transaction on an external 16-bit SRAM.
- Drives `ready` low to freeze the upstream pipeline while the transaction runs.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- ADDRESS_LEN, 32, data and address width of the pipeline.
- BASE_ADDR, 1024, first byte address of data memory; subtracted from the ALU result.
- SRAM_ADDR_W, 18, SRAM halfword address width.
- WAIT_CYCLES, 1, extra hold cycles per SRAM access; 0 is legal.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_res  in  ADDRESS_LEN  address for load/store; result for other instructions.
- val_rm  in  ADDRESS_LEN  store data.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- wb_en  in  1  write-back enable.
- dest  in  4  destination register.
- ready  out  1  1 = stage can advance; 0 = freeze PC, IF/ID/EXE registers and hazard unit.
- sram_addr  out  SRAM_ADDR_W  halfword address.
- sram_dq_out  out  16  write data.
- sram_dq_in  in  16  read data.
- sram_we_n  out  1  active-low write strobe.
- wb_en_out  out  1  MEM/WB register output.
- mem_r_en_out  out  1  MEM/WB register output.
- alu_res_out  out  ADDRESS_LEN  MEM/WB register output.
- mem_data_out  out  ADDRESS_LEN  MEM/WB register output; loaded word.
- dest_out  out  4  MEM/WB register output.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state goes to IDLE and the wait counter to 0. All MEM/WB outputs become 0, `sram_we_n`=1, `sram_addr`=0, `sram_dq_out`=0. These take effect at the next clock edge.
- Reset mid-transaction aborts it, with no further SRAM write strobe after that edge.
- Address mapping: off = alu_res − BASE_ADDR (modulo 2^ADDRESS_LEN); word = off[ADDRESS_LEN-1:2].
  - Low half goes to halfword address {word,0}; high half to {word,1}, each truncated to SRAM_ADDR_W.
  - Addresses below BASE_ADDR wrap; no error is flagged.
- Request: req = mem_r_en | mem_w_en. If both are set, the access is treated as a store.
- FSM states and transitions:
  - IDLE: if req, go to LO (RD_LO or WR_LO) and clear the counter; `ready`=0. If no req, `ready`=1.
  - RD_LO / WR_LO: hold for WAIT_CYCLES+1 cycles, with the counter incrementing. On the last cycle go to the matching HI state and clear the counter. `ready`=0.
  - RD_HI / WR_HI: same hold, then go to DONE. `ready`=0.
  - DONE: `ready`=1 for exactly one cycle, then IDLE.
- `ready` is combinational from state and req.
- Reads:
  - `sram_we_n`=1 throughout.
  - `sram_dq_in` is sampled on the last cycle of RD_LO into data[15:0], and on the last cycle of RD_HI into data[31:16].
- Writes:
  - `sram_we_n`=0 on every cycle of WR_LO and WR_HI; =1 in IDLE and DONE.
  - `sram_dq_out` = val_rm[15:0] in WR_LO and val_rm[31:16] in WR_HI.
  - `sram_addr` is stable for the whole phase.
- Upstream inputs are held stable by the freeze while `ready`=0. The block does not re-latch them.
- MEM/WB register, on each edge (when not in reset):
  - If `ready`=1: capture wb_en, mem_r_en, alu_res, dest; mem_data_out captures the assembled word on DONE and is unchanged otherwise.
  - If `ready`=0: wb_en_out←0 (bubble); other outputs hold.
- Latency:
  - Non-memory instruction: 1 cycle, `ready` never drops.
  - Load or store: `ready` low for 2·WAIT_CYCLES+3 cycles, then high in DONE; result visible the edge after DONE.
- Back-to-back memory operations: the DONE cycle advances EXE, and the next instruction starts from IDLE on the following cycle.

Test Plan:
- Reset: assert rst 2 cycles with req=1 → all outputs 0, `sram_we_n`=1. First cycle after release, `ready`=0 (req seen).
- Store, WAIT_CYCLES=1: alu_res=1024, val_rm=0x12345678, mem_w_en=1 → SRAM[0]=0x5678, SRAM[1]=0x1234. `sram_we_n` low 2+2 cycles, `ready` low 5 cycles, wb_en_out stays 0.
- Load, WAIT_CYCLES=1: then mem_r_en=1, wb_en=1, dest=3, alu_res=1024 → mem_data_out=0x12345678, mem_r_en_out=1, wb_en_out=1, dest_out=3 one edge after DONE.
- Address 1028 store 0xCAFEBABE → writes go to halfword addresses 2 (0xBABE) and 3 (0xCAFE). Non-memory op alu_res=0x55, wb_en=1 → alu_res_out=0x55 next edge, `ready` stays 1.
- WAIT_CYCLES=0, load → `ready` low exactly 3 cycles; total 4 cycles from request to DONE.
- rst asserted during WR_HI → `sram_we_n`=1 next edge, state IDLE, SRAM[hi] not written further; the following load restarts cleanly.

Source files
------------

// File: rtl/mem_stage_sram.sv
// rtl/mem_stage_sram.sv - memory stage: load/store over a 16-bit SRAM plus MEM/WB register
module mem_stage_sram #(
  parameter int ADDRESS_LEN = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] alu_res,
  input  logic [ADDRESS_LEN-1:0] val_rm,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic                   wb_en,
  input  logic [3:0]             dest,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n,
  output logic                   wb_en_out,
  output logic                   mem_r_en_out,
  output logic [ADDRESS_LEN-1:0] alu_res_out,
  output logic [ADDRESS_LEN-1:0] mem_data_out,
  output logic [3:0]             dest_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Counter must hold 0..WAIT_CYCLES; keep at least one bit when no wait is needed.
  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req;
  logic             last;
  logic [SRAM_ADDR_W-1:0] hw_lo, hw_hi;
  logic [15:0]      data_lo, data_hi;

  assign req  = mem_r_en | mem_w_en;
  assign last = (cnt == CNT_LAST);

  // Word index of the offset, doubled to a halfword address; below-base addresses simply wrap.
  assign hw_lo = SRAM_ADDR_W'(((alu_res - ADDRESS_LEN'(BASE_ADDR)) >> 2) << 1);
  assign hw_hi = {hw_lo[SRAM_ADDR_W-1:1], 1'b1};

  // State and hold-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and the freeze signal; a simultaneous read+write request is a store.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ready      = 1'b0;
    case (state)
      IDLE: begin
        ready = !req;
        if (req) begin
          state_next = mem_w_en ? WR_LO : RD_LO;
          cnt_next   = '0;
        end
      end
      RD_LO, WR_LO: begin
        if (last) begin
          state_next = (state == WR_LO) ? WR_HI : RD_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RD_HI, WR_HI: begin
        if (last) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // SRAM pins decoded from state so address, data and strobe are steady across a whole phase.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_we_n   = 1'b1;
    case (state)
      RD_LO: sram_addr = hw_lo;
      RD_HI: sram_addr = hw_hi;
      WR_LO: begin
        sram_addr   = hw_lo;
        sram_dq_out = val_rm[15:0];
        sram_we_n   = 1'b0;
      end
      WR_HI: begin
        sram_addr   = hw_hi;
        sram_dq_out = val_rm[31:16];
        sram_we_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // Sample read data on the final hold cycle of each read phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_lo <= '0;
      data_hi <= '0;
    end else if (state == RD_LO && last) begin
      data_lo <= sram_dq_in;
    end else if (state == RD_HI && last) begin
      data_hi <= sram_dq_in;
    end
  end

  // MEM/WB register: advance when ready, otherwise inject a write-back bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else if (ready) begin
      wb_en_out    <= wb_en;
      mem_r_en_out <= mem_r_en;
      alu_res_out  <= alu_res;
      dest_out     <= dest;
      if (state == DONE) begin
        mem_data_out <= ADDRESS_LEN'({data_hi, data_lo});
      end
    end else begin
      wb_en_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// tb/tb_mem_stage_sram.sv - directed-vector bench for mem_stage_sram
module tb_mem_stage_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, WAIT_CYCLES = 1
  logic        rst;
  logic [31:0] alu_res, val_rm;
  logic        mem_r_en, mem_w_en, wb_en;
  logic [3:0]  dest;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_we_n;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  // Second instance, WAIT_CYCLES = 0
  logic        b_rst;
  logic [31:0] b_alu_res, b_val_rm;
  logic        b_mem_r_en, b_mem_w_en, b_wb_en;
  logic [3:0]  b_dest;
  logic        b_ready;
  logic [17:0] b_sram_addr;
  logic [15:0] b_sram_dq_out, b_sram_dq_in;
  logic        b_sram_we_n;
  logic        b_wb_en_out, b_mem_r_en_out;
  logic [31:0] b_alu_res_out, b_mem_data_out;
  logic [3:0]  b_dest_out;

  mem_stage_sram #(.ADDRESS_LEN(32), .BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .alu_res(alu_res), .val_rm(val_rm),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .dest(dest),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out)
  );

  mem_stage_sram #(.ADDRESS_LEN(32), .BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(b_rst), .alu_res(b_alu_res), .val_rm(b_val_rm),
    .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en), .wb_en(b_wb_en), .dest(b_dest),
    .ready(b_ready), .sram_addr(b_sram_addr), .sram_dq_out(b_sram_dq_out),
    .sram_dq_in(b_sram_dq_in), .sram_we_n(b_sram_we_n),
    .wb_en_out(b_wb_en_out), .mem_r_en_out(b_mem_r_en_out), .alu_res_out(b_alu_res_out),
    .mem_data_out(b_mem_data_out), .dest_out(b_dest_out)
  );

  // SRAM models: asynchronous read, write on the clock edge while we_n is low.
  logic [15:0] mem  [256] = '{default: 16'h0000};
  logic [15:0] mem0 [256] = '{4: 16'hBEEF, 5: 16'hDEAD, default: 16'h0000};
  logic [33:0] wlog [$];

  assign sram_dq_in   = mem[sram_addr[7:0]];
  assign b_sram_dq_in = mem0[b_sram_addr[7:0]];

  always @(posedge clk) begin
    if (!sram_we_n) begin
      mem[sram_addr[7:0]] <= sram_dq_out;
      wlog.push_back({sram_addr, sram_dq_out});
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] rm;
    logic        r;
    logic        w;
    logic        wb;
    logic [3:0]  dst;
    int          exp_low;
    logic        exp_wb;
    logic        exp_r;
    logic [31:0] exp_data;
    int          exp_writes;
    logic [17:0] lo_addr;
    logic [15:0] lo_val;
    logic [15:0] hi_val;
  } vec_t;

  vec_t vecs [9];

  task automatic run_op(input vec_t v);
    int   low;
    bit   bubble_bad;
    logic [33:0] e;
    @(negedge clk);
    alu_res  = v.alu;
    val_rm   = v.rm;
    mem_r_en = v.r;
    mem_w_en = v.w;
    wb_en    = v.wb;
    dest     = v.dst;
    wlog.delete();
    low = 0;
    bubble_bad = 0;
    #1;
    while (!ready && low < 40) begin
      if (low >= 1 && wb_en_out) bubble_bad = 1;
      low++;
      @(negedge clk);
      #1;
    end
    check({v.name, "_ready_low"}, 32'(low), 32'(v.exp_low));
    if (v.exp_low > 0) check({v.name, "_bubble"}, 32'(bubble_bad), 32'd0);
    @(posedge clk);
    #1;
    check({v.name, "_wb_en_out"}, 32'(wb_en_out), 32'(v.exp_wb));
    check({v.name, "_mem_r_en_out"}, 32'(mem_r_en_out), 32'(v.exp_r));
    check({v.name, "_alu_res_out"}, alu_res_out, v.alu);
    check({v.name, "_mem_data_out"}, mem_data_out, v.exp_data);
    check({v.name, "_dest_out"}, 32'(dest_out), 32'(v.dst));
    check({v.name, "_write_count"}, 32'(wlog.size()), 32'(v.exp_writes));
    if (v.exp_writes > 0 && wlog.size() > 0) begin
      e = wlog[0];
      check({v.name, "_lo_addr"}, 32'(e[33:16]), 32'(v.lo_addr));
      check({v.name, "_lo_data"}, 32'(e[15:0]), 32'(v.lo_val));
      e = wlog[wlog.size() - 1];
      check({v.name, "_hi_addr"}, 32'(e[33:16]), 32'(v.lo_addr | 18'd1));
      check({v.name, "_hi_data"}, 32'(e[15:0]), 32'(v.hi_val));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   low;
    vec_t v;

    //         name            alu            rm             r  w  wb dst   low wb r  data           wr lo_addr      lo        hi
    vecs[0] = '{"store_1024",  32'd1024,      32'h12345678, 0, 1, 0, 4'd0,  5, 0, 0, 32'h00000000, 4, 18'h00000, 16'h5678, 16'h1234};
    vecs[1] = '{"load_1024",   32'd1024,      32'h0,        1, 0, 1, 4'd3,  5, 1, 1, 32'h12345678, 0, 18'h00000, 16'h0000, 16'h0000};
    vecs[2] = '{"store_1028",  32'd1028,      32'hCAFEBABE, 0, 1, 0, 4'd0,  5, 0, 0, 32'h12345678, 4, 18'h00002, 16'hBABE, 16'hCAFE};
    vecs[3] = '{"alu_55",      32'h00000055,  32'h0,        0, 0, 1, 4'd7,  0, 1, 0, 32'h12345678, 0, 18'h00000, 16'h0000, 16'h0000};
    vecs[4] = '{"load_1028",   32'd1028,      32'h0,        1, 0, 1, 4'd9,  5, 1, 1, 32'hCAFEBABE, 0, 18'h00000, 16'h0000, 16'h0000};
    vecs[5] = '{"store_wrap",  32'd1020,      32'hA5A55A5A, 0, 1, 0, 4'd0,  5, 0, 0, 32'hCAFEBABE, 4, 18'h3FFFE, 16'h5A5A, 16'hA5A5};
    vecs[6] = '{"load_wrap",   32'd1020,      32'h0,        1, 0, 1, 4'd1,  5, 1, 1, 32'hA5A55A5A, 0, 18'h00000, 16'h0000, 16'h0000};
    vecs[7] = '{"alu_nowb",    32'hFFFFFFFF,  32'h0,        0, 0, 0, 4'd15, 0, 0, 0, 32'hA5A55A5A, 0, 18'h00000, 16'h0000, 16'h0000};
    vecs[8] = '{"store_both",  32'd1036,      32'h0BADF00D, 1, 1, 1, 4'd2,  5, 1, 1, 32'hA5A55A5A, 4, 18'h00006, 16'hF00D, 16'h0BAD};

    rst = 1; alu_res = 32'd1024; val_rm = 0; mem_r_en = 1; mem_w_en = 0; wb_en = 1; dest = 4'd5;
    b_rst = 1; b_alu_res = 0; b_val_rm = 0; b_mem_r_en = 0; b_mem_w_en = 0; b_wb_en = 0; b_dest = 0;

    // Reset held two cycles with a request pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_wb_en_out", 32'(wb_en_out), 32'd0);
    check("rst_mem_r_en_out", 32'(mem_r_en_out), 32'd0);
    check("rst_alu_res_out", alu_res_out, 32'd0);
    check("rst_mem_data_out", mem_data_out, 32'd0);
    check("rst_dest_out", 32'(dest_out), 32'd0);
    check("rst_sram_we_n", 32'(sram_we_n), 32'd1);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_sram_dq_out", 32'(sram_dq_out), 32'd0);
    @(negedge clk);
    rst = 0; b_rst = 0;
    #1;
    check("rst_release_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1; mem_r_en = 0; wb_en = 0;
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Reset during WR_HI aborts the store
    @(negedge clk);
    alu_res = 32'd1032; val_rm = 32'h11112222; mem_r_en = 0; mem_w_en = 1; wb_en = 0; dest = 0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_wr_hi_we_n", 32'(sram_we_n), 32'd0);
    check("abort_in_wr_hi_addr", 32'(sram_addr), 32'd5);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    wlog.delete();
    @(negedge clk);
    rst = 0; mem_w_en = 0;
    repeat (3) @(negedge clk);
    check("abort_no_more_writes", 32'(wlog.size()), 32'd0);
    v = '{"load_after_abort", 32'd1032, 32'h0, 1, 0, 1, 4'd4, 5, 1, 1, 32'h11112222, 0, 18'h0, 16'h0, 16'h0};
    run_op(v);
    @(negedge clk);
    mem_r_en = 0; wb_en = 0;

    // WAIT_CYCLES = 0 load
    @(negedge clk);
    b_alu_res = 32'd1032; b_mem_r_en = 1; b_wb_en = 1; b_dest = 4'd6;
    low = 0;
    #1;
    while (!b_ready && low < 40) begin
      low++;
      @(negedge clk);
      #1;
    end
    check("w0_ready_low", 32'(low), 32'd3);
    @(posedge clk);
    #1;
    check("w0_mem_data_out", b_mem_data_out, 32'hDEADBEEF);
    check("w0_wb_en_out", 32'(b_wb_en_out), 32'd1);
    check("w0_dest_out", 32'(b_dest_out), 32'd6);
    @(negedge clk);
    b_mem_r_en = 0; b_wb_en = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
